// File: rtl/sgbm_pix_rx.sv
// Grey-pixel stream receiver: raster-order checker feeding two ping-pong row banks,
// with a random-access read port and row-ready/release handshake for the cost stage.
module sgbm_pix_rx #(
   parameter int IMAGE_ROW = 200,
   parameter int IMAGE_COL = 400,
   parameter int PIX_W     = 8,
   parameter int COORD_W   = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [PIX_W-1:0]   in_grey_left,
   input  logic [PIX_W-1:0]   in_grey_right,
   input  logic [COORD_W-1:0] in_row,
   input  logic [COORD_W-1:0] in_col,
   output logic               row_ready,
   output logic [COORD_W-1:0] row_idx,
   input  logic               rd_en,
   input  logic [COORD_W-1:0] rd_col,
   output logic [PIX_W-1:0]   rd_left,
   output logic [PIX_W-1:0]   rd_right,
   output logic               rd_valid,
   input  logic               row_release,
   output logic               frame_done,
   output logic               seq_err,
   output logic               overflow
);

   localparam int DW = 2 * PIX_W;
   localparam int AW = $clog2(2 * IMAGE_COL);
   localparam logic [COORD_W-1:0] NROW     = COORD_W'(IMAGE_ROW);
   localparam logic [COORD_W-1:0] NCOL     = COORD_W'(IMAGE_COL);
   localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMAGE_ROW - 1);
   localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMAGE_COL - 1);
   localparam logic [AW-1:0]      BANK1    = AW'(IMAGE_COL);

   logic [DW-1:0] mem [2*IMAGE_COL];
   logic [DW-1:0] ram_rd_q;

   logic [COORD_W-1:0] exp_row_q, exp_row_d;
   logic [COORD_W-1:0] exp_col_q, exp_col_d;
   logic               drop_q, drop_d;
   logic               wr_bank_q, wr_bank_d;
   logic               rd_bank_q, rd_bank_d;
   logic [1:0]         full_q, full_d;
   logic [COORD_W-1:0] tag_q [2];
   logic [COORD_W-1:0] tag_d [2];
   logic               row_ready_q, row_ready_d;
   logic [COORD_W-1:0] row_idx_q, row_idx_d;
   logic               rd_valid_q, rd_valid_d;
   logic               data_clr_q, data_clr_d;
   logic               frame_done_q, frame_done_d;
   logic               seq_err_q, seq_err_d;
   logic               overflow_q, overflow_d;

   logic          we, rd_ok, rel_ok, wr_full, in_match;
   logic [AW-1:0] waddr, raddr;
   logic [DW-1:0] wdata;

   assign waddr = wr_bank_q ? BANK1 + AW'(in_col) : AW'(in_col);
   assign raddr = rd_bank_q ? BANK1 + AW'(rd_col) : AW'(rd_col);
   assign wdata = {in_grey_left, in_grey_right};

   always_comb begin
      exp_row_d    = exp_row_q;
      exp_col_d    = exp_col_q;
      drop_d       = drop_q;
      wr_bank_d    = wr_bank_q;
      rd_bank_d    = rd_bank_q;
      full_d       = full_q;
      tag_d        = tag_q;
      data_clr_d   = data_clr_q;
      frame_done_d = 1'b0;
      seq_err_d    = seq_err_q;
      overflow_d   = overflow_q;
      we           = 1'b0;

      rel_ok   = row_release && row_ready_q;
      rd_ok    = rd_en && row_ready_q && (rd_col < NCOL);
      // A release landing on the bank we are about to write frees it this cycle.
      wr_full  = full_q[wr_bank_q] && !(rel_ok && (rd_bank_q == wr_bank_q));
      in_match = (in_row == exp_row_q) && (in_col == exp_col_q) &&
                 (in_row < NROW) && (in_col < NCOL);

      rd_valid_d = rd_ok;
      if (rd_ok) data_clr_d = 1'b0;

      if (rel_ok) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
      end

      if (in_valid) begin
         if (in_col == '0 && in_row < NROW) begin
            // Every col-0 pixel (re)starts a row; the full check decides drop.
            if (!in_match) seq_err_d = 1'b1;
            exp_row_d = in_row;
            exp_col_d = COORD_W'(1);
            if (wr_full) begin
               overflow_d = 1'b1;
               drop_d     = 1'b1;
            end else begin
               drop_d = 1'b0;
               we     = 1'b1;
            end
         end else if (in_match) begin
            we = !drop_q;
            if (in_col == LAST_COL) begin
               exp_col_d = '0;
               exp_row_d = (in_row == LAST_ROW) ? '0 : in_row + 1'b1;
               if (!drop_q) begin
                  full_d[wr_bank_q] = 1'b1;
                  tag_d[wr_bank_q]  = in_row;
                  wr_bank_d         = ~wr_bank_q;
                  frame_done_d      = (in_row == LAST_ROW);
               end
            end else begin
               exp_col_d = exp_col_q + 1'b1;
            end
         end else begin
            seq_err_d = 1'b1;
         end
      end

      row_ready_d = full_d[rd_bank_d];
      row_idx_d   = tag_d[rd_bank_d];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_row_q    <= '0;
         exp_col_q    <= '0;
         drop_q       <= 1'b0;
         wr_bank_q    <= 1'b0;
         rd_bank_q    <= 1'b0;
         full_q       <= '0;
         tag_q[0]     <= '0;
         tag_q[1]     <= '0;
         row_ready_q  <= 1'b0;
         row_idx_q    <= '0;
         rd_valid_q   <= 1'b0;
         data_clr_q   <= 1'b1;
         frame_done_q <= 1'b0;
         seq_err_q    <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         exp_row_q    <= exp_row_d;
         exp_col_q    <= exp_col_d;
         drop_q       <= drop_d;
         wr_bank_q    <= wr_bank_d;
         rd_bank_q    <= rd_bank_d;
         full_q       <= full_d;
         tag_q        <= tag_d;
         row_ready_q  <= row_ready_d;
         row_idx_q    <= row_idx_d;
         rd_valid_q   <= rd_valid_d;
         data_clr_q   <= data_clr_d;
         frame_done_q <= frame_done_d;
         seq_err_q    <= seq_err_d;
         overflow_q   <= overflow_d;
      end
   end

   // Row storage carries no reset; data_clr_q masks it to zero until the first read.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (rd_ok) ram_rd_q <= mem[raddr];
   end

   assign row_ready  = row_ready_q;
   assign row_idx    = row_idx_q;
   assign rd_valid   = rd_valid_q;
   assign rd_left    = data_clr_q ? '0 : ram_rd_q[DW-1:PIX_W];
   assign rd_right   = data_clr_q ? '0 : ram_rd_q[PIX_W-1:0];
   assign frame_done = frame_done_q;
   assign seq_err    = seq_err_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_sgbm_pix_rx.sv
// Bench for sgbm_pix_rx on a shortened frame (6 rows of 400): directed sequences, a read-port
// vector table and a random phase, all checked against a row-queue reference model.
module tb_sgbm_pix_rx;
   localparam int R = 6;
   localparam int C = 400;
   localparam int GAP = 13;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_grey_left = '0, in_grey_right = '0;
   logic [9:0] in_row = '0, in_col = '0;
   logic       row_ready;
   logic [9:0] row_idx;
   logic       rd_en = 1'b0;
   logic [9:0] rd_col = '0;
   logic [7:0] rd_left, rd_right;
   logic       rd_valid;
   logic       row_release = 1'b0;
   logic       frame_done, seq_err, overflow;

   always #5 clk = ~clk;

   sgbm_pix_rx #(.IMAGE_ROW(R), .IMAGE_COL(C), .PIX_W(8), .COORD_W(10)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .in_grey_left(in_grey_left), .in_grey_right(in_grey_right),
      .in_row(in_row), .in_col(in_col), .row_ready(row_ready), .row_idx(row_idx),
      .rd_en(rd_en), .rd_col(rd_col), .rd_left(rd_left), .rd_right(rd_right),
      .rd_valid(rd_valid), .row_release(row_release), .frame_done(frame_done),
      .seq_err(seq_err), .overflow(overflow)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: completed rows form a FIFO of depth 2 (head = row being read).
   int          m_er, m_ec, m_cnt;
   bit          m_drop, m_seq, m_ovf, m_fd, m_rv;
   logic [15:0] m_rd;
   int          q_idx [2];
   logic [15:0] q_pix [2][C];
   logic [15:0] cur_pix [C];

   function automatic logic [7:0] pix_l(input int r, input int c);
      return 8'((r + c) & 255);
   endfunction

   function automatic logic [7:0] pix_r(input int r, input int c);
      return pix_l(r, c) ^ 8'h5A;
   endfunction

   function void model_reset();
      m_er = 0; m_ec = 0; m_cnt = 0; m_drop = 0;
      m_seq = 0; m_ovf = 0; m_fd = 0; m_rv = 0; m_rd = '0;
   endfunction

   function void model_edge();
      bit ready, rel_ok;
      int row, col;
      logic [15:0] d;
      if (!rst_n) begin
         model_reset();
         return;
      end
      ready = (m_cnt > 0);
      m_fd  = 0;
      m_rv  = rd_en && ready && (int'(rd_col) < C);
      if (m_rv) m_rd = q_pix[0][rd_col];
      rel_ok = row_release && ready;
      if (rel_ok) begin
         for (int i = 0; i < C; i++) q_pix[0][i] = q_pix[1][i];
         q_idx[0] = q_idx[1];
         m_cnt--;
      end
      if (in_valid) begin
         row = int'(in_row);
         col = int'(in_col);
         d   = {in_grey_left, in_grey_right};
         if (col == 0 && row < R) begin
            if (!(row == m_er && m_ec == 0)) m_seq = 1;
            m_er = row;
            m_ec = 1;
            if (m_cnt == 2) begin
               m_ovf = 1; m_drop = 1;
            end else begin
               m_drop = 0; cur_pix[0] = d;
            end
         end else if (row == m_er && col == m_ec && row < R && col < C) begin
            if (!m_drop) cur_pix[col] = d;
            if (col == C - 1) begin
               m_ec = 0;
               m_er = (row + 1) % R;
               if (!m_drop) begin
                  for (int i = 0; i < C; i++) q_pix[m_cnt][i] = cur_pix[i];
                  q_idx[m_cnt] = row;
                  m_cnt++;
                  m_fd = (row == R - 1);
               end
            end else begin
               m_ec++;
            end
         end else begin
            m_seq = 1;
         end
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_model();
      chk("row_ready", row_ready, m_cnt > 0);
      if (m_cnt > 0) chk("row_idx", row_idx, q_idx[0]);
      chk("rd_valid", rd_valid, m_rv);
      chk("rd_left", rd_left, m_rd[15:8]);
      chk("rd_right", rd_right, m_rd[7:0]);
      chk("frame_done", frame_done, m_fd);
      chk("seq_err", seq_err, m_seq);
      chk("overflow", overflow, m_ovf);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk_model();
      in_valid = 0; rd_en = 0; row_release = 0;
   endtask

   task automatic send_pix(input int row, input int col);
      in_valid = 1; in_row = 10'(row); in_col = 10'(col);
      in_grey_left = pix_l(row, col); in_grey_right = pix_r(row, col);
      step();
   endtask

   task automatic send_row(input int row);
      for (int c = 0; c < C; c++) send_pix(row, c);
   endtask

   task automatic release_row();
      row_release = 1;
      step();
   endtask

   task automatic read_col(input int col);
      rd_en = 1; rd_col = 10'(col);
      step();
   endtask

   task automatic do_reset();
      rst_n = 0;
      model_reset();
      step();
      step();
      @(negedge clk);
      rst_n = 1;
   endtask

   typedef struct {
      logic ren; int col; logic rel;
      logic exp_valid; logic exp_ready; int exp_left;
   } rvec_t;
   rvec_t tbl [7];

   initial begin
      int pr, pc, ph, rs, rc, nready, nfd, nreads, cyc, issued, sr, sc;

      // Read-port vectors applied while row 4 sits in the read bank.
      tbl[0] = '{1'b1, C,     1'b0, 1'b0, 1'b1, -1};
      tbl[1] = '{1'b1, C - 1, 1'b0, 1'b1, 1'b1, int'(pix_l(4, C - 1))};
      tbl[2] = '{1'b1, 0,     1'b0, 1'b1, 1'b1, int'(pix_l(4, 0))};
      tbl[3] = '{1'b0, 5,     1'b0, 1'b0, 1'b1, int'(pix_l(4, 0))};
      tbl[4] = '{1'b1, 3,     1'b1, 1'b1, 1'b0, int'(pix_l(4, 3))};
      tbl[5] = '{1'b1, C - 1, 1'b0, 1'b0, 1'b0, int'(pix_l(4, 3))};
      tbl[6] = '{1'b0, 0,     1'b1, 1'b0, 1'b0, int'(pix_l(4, 3))};

      // Reset state
      do_reset();
      chk("reset_row_ready", row_ready, 0);
      chk("reset_row_idx", row_idx, 0);
      chk("reset_rd_valid", rd_valid, 0);
      chk("reset_rd_left", rd_left, 0);
      chk("reset_seq_err", seq_err, 0);
      chk("reset_overflow", overflow, 0);
      chk("reset_frame_done", frame_done, 0);

      // Full frame, one pixel every GAP cycles, reader drains and releases each row
      pr = 0; pc = 0; ph = 0; rs = 0; rc = 0;
      nready = 0; nfd = 0; nreads = 0; cyc = 0;
      while ((pr < R || rs != 0 || nready < R) && cyc < 40000) begin
         issued = -1;
         if (ph == 0 && pr < R) begin
            in_valid = 1; in_row = 10'(pr); in_col = 10'(pc);
            in_grey_left = pix_l(pr, pc); in_grey_right = pix_r(pr, pc);
            if (pc == C - 1) begin pc = 0; pr++; end else pc++;
         end
         ph = (ph + 1) % GAP;
         case (rs)
            0: if (row_ready) begin
                  chk("frame_row_idx", row_idx, nready);
                  nready++; rs = 1; rc = 0;
               end
            1: begin
                  rd_en = 1; rd_col = 10'(rc); issued = rc; rc++;
                  if (rc == C) rs = 2;
               end
            default: begin row_release = 1; rs = 0; end
         endcase
         step();
         if (frame_done) nfd++;
         if (issued >= 0) begin
            chk("frame_rd_valid", rd_valid, 1);
            if (rd_left == pix_l(nready - 1, issued) && rd_right == pix_r(nready - 1, issued))
               nreads++;
         end
         cyc++;
      end
      chk("frame_timeout", cyc < 40000, 1);
      chk("frame_rows", nready, R);
      chk("frame_reads", nreads, R * C);
      chk("frame_done_count", nfd, 1);
      chk("frame_seq_err", seq_err, 0);
      chk("frame_overflow", overflow, 0);

      // No release: third row overflows and is dropped
      do_reset();
      send_row(0); send_row(1); send_row(2);
      chk("ovf_ready", row_ready, 1);
      chk("ovf_idx0", row_idx, 0);
      chk("ovf_flag", overflow, 1);
      release_row();
      chk("ovf_idx1", row_idx, 1);
      send_row(3);
      release_row();
      chk("ovf_idx3", row_idx, 3);
      read_col(10);
      chk("ovf_row3_data", rd_left, pix_l(3, 10));

      // Out-of-order column, then col-0 resync of row 4
      do_reset();
      for (int r = 0; r < 4; r++) begin send_row(r); release_row(); end
      for (int c = 0; c < 5; c++) send_pix(4, c);
      chk("seq_before", seq_err, 0);
      send_pix(4, 7);
      chk("seq_set", seq_err, 1);
      send_row(4);
      chk("seq_ready", row_ready, 1);
      chk("seq_idx4", row_idx, 4);

      // Read-port table on row 4
      for (int i = 0; i < 7; i++) begin
         rd_en = tbl[i].ren; rd_col = 10'(tbl[i].col); row_release = tbl[i].rel;
         step();
         chk($sformatf("tbl%0d_valid", i), rd_valid, tbl[i].exp_valid);
         chk($sformatf("tbl%0d_ready", i), row_ready, tbl[i].exp_ready);
         if (tbl[i].exp_left >= 0)
            chk($sformatf("tbl%0d_left", i), rd_left, tbl[i].exp_left);
      end

      // Asynchronous reset mid-row
      do_reset();
      send_row(0); release_row(); send_row(1); send_row(2);
      read_col(5);
      for (int c = 0; c < 200; c++) send_pix(3, c);
      #3;
      rst_n = 0;
      #1;
      chk("arst_row_ready", row_ready, 0);
      chk("arst_row_idx", row_idx, 0);
      chk("arst_rd_left", rd_left, 0);
      chk("arst_rd_right", rd_right, 0);
      chk("arst_rd_valid", rd_valid, 0);
      chk("arst_overflow", overflow, 0);
      chk("arst_seq_err", seq_err, 0);
      model_reset();
      step(); step();
      @(negedge clk);
      rst_n = 1;
      send_row(0);
      chk("arst_restart_seq", seq_err, 0);
      chk("arst_restart_ready", row_ready, 1);
      chk("arst_restart_idx", row_idx, 0);

      // Release coinciding with col 0 into the full bank
      do_reset();
      send_row(0); send_row(1);
      row_release = 1;
      send_pix(2, 0);
      chk("simul_overflow", overflow, 0);
      for (int c = 1; c < C; c++) send_pix(2, c);
      release_row();
      chk("simul_idx2", row_idx, 2);
      read_col(0);
      chk("simul_data", rd_left, pix_l(2, 0));

      // Randomized traffic against the model
      do_reset();
      sr = 0; sc = 0;
      for (int i = 0; i < 5000; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            int k;
            k = int'($urandom_range(0, 39));
            in_valid = 1;
            in_grey_left = 8'($urandom()); in_grey_right = 8'($urandom());
            if (k == 0) begin
               in_row = 10'($urandom_range(0, R + 1)); in_col = 10'($urandom_range(0, C + 2));
            end else if (k == 1) begin
               sr = int'($urandom_range(0, R - 1));
               in_row = 10'(sr); in_col = 0; sc = 1;
            end else begin
               in_row = 10'(sr); in_col = 10'(sc);
               if (sc == C - 1) begin sc = 0; sr = (sr + 1) % R; end else sc++;
            end
         end
         rd_en = 1'($urandom_range(0, 1));
         rd_col = 10'($urandom_range(0, C + 3));
         row_release = ($urandom_range(0, 299) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
